lsu_dual_port: RTL and testbench
================================

# lsu_dual_port

Dual-slot load/store unit between the execute/LSU pipeline buffer and the writeback buffer. It takes the two-slot bundle held in the LSU buffer and serialises its memory operations onto a single data-memory request/grant port, slot 0 first. It drives `mem_stall_o` so the backend holds while any access is outstanding. It produces per-slot results for the LSU/writeback buffer: load data when the slot is a load, otherwise the ALU value.

## Interface
- `ADDR_W`, default 32: data-memory byte-address width.
- `clock_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `adv_i`  in  1  backend write enable; the LSU buffer loads a new bundle at this edge.
- `alu_0_i`, `alu_1_i`  in  32  ALU result per slot; this is the effective address for memory ops.
- `ctrl0_i`, `ctrl1_i`  in  `CTRL_BUS`  per-slot control word. Zero means bubble.
- `st_data_0_i`, `st_data_1_i`  in  32  rs2 store data per slot.
- `dmem_req_o`  out  1  request valid; held until `dmem_gnt_i`.
- `dmem_we_o`  out  1  1 = store.
- `dmem_addr_o`  out  ADDR_W  word-aligned address; low two bits are 0.
- `dmem_be_o`  out  4  byte enables.
- `dmem_wdata_o`  out  32  lane-shifted store data.
- `dmem_gnt_i`  in  1  request accepted this cycle.
- `dmem_rvalid_i`, `dmem_rdata_i`  in  1, 32  load response, arriving at least 1 cycle after grant.
- `mem_stall_o`  out  1  backend stall request.
- `res_0_o`, `res_1_o`  out  32  per-slot result to writeback.
- `misalign_o`  out  2  per-slot misalignment flag, valid in DONE.

## Operation
- A slot is a memory op when `ctrl[MEM_READ]` or `ctrl[MEM_WRITE]` is set. Size comes from `ctrl[MEM_SIZE]` (0 = byte, 1 = half, 2 = word). `ctrl[MEM_UNSIGNED]` selects zero extension.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
- IDLE:
  - Slot 0 is a memory op → REQ0.
  - Otherwise, slot 1 is a memory op → REQ1.
  - Otherwise stay in IDLE.
- REQx: drive the request from slot x. On `dmem_gnt_i`:
  - store → next slot (REQ1 if x=0 and slot 1 is a memory op), else DONE;
  - load → WAITx.
- WAITx: on `dmem_rvalid_i`, capture the extended data into `ld_x`, then go to the next slot or DONE.
- DONE: hold results. On `adv_i`, go to IDLE. A store is never re-issued while the bundle is held by other stages' stalls.
- Misaligned access (half with addr[0]=1, or word with addr[1:0]≠0):
  - no request is issued for that slot;
  - `misalign_o[x]` is set;
  - `res_x` is 0;
  - the FSM proceeds as if the slot were complete.
- Byte enables: byte → `1<<addr[1:0]`; half → `3<<addr[1:0]`; word → `4'hF`. `wdata` is replicated across lanes by size.
- Load extraction: shift `rdata` right by 8×addr[1:0], then sign- or zero-extend by size.
- `mem_stall_o` is 1 whenever the state is REQ0, REQ1, WAIT0 or WAIT1, or (state is IDLE and any slot is a memory op). Otherwise 0.
- `res_x_o` = `ld_x` if slot x is a load, else `alu_x_i`. This mux is combinational.

## Timing
- Reset values: state IDLE; `dmem_req_o`, `dmem_we_o`, `dmem_addr_o`, `dmem_be_o`, `dmem_wdata_o` all 0; `ld_0`, `ld_1`, `misalign_o` all 0.
- All `dmem_*` outputs are registered from state and slot; the request first appears the cycle after the bundle is seen in IDLE.
- Single load with grant on first request and `rvalid` one cycle later:
  - stall high for 3 cycles (IDLE-detect, REQ0, WAIT0);
  - DONE in cycle 3 with stall low.
- Two stores granted immediately: stall high for 3 cycles.
- Bundle with no memory op: zero stall cycles; the FSM stays in IDLE.
- Reset mid-access:
  - request dropped next cycle;
  - a late `rvalid` after reset is ignored, since only WAIT states accept it.
- `rvalid` in the same cycle as `gnt` is illegal (protocol rule); a bench assertion checks it.

## Structure
- Add to `src/defs.v`: control-word fields `MEM_READ`, `MEM_WRITE`, `MEM_SIZE`, `MEM_UNSIGNED`, and the FSM state encodings.
- One sub-module, `lsu_align`: combinational byte-enable, store-lane and load-extract logic, instanced once per slot.

## Test plan
- Slot 0 = LW at 0x100, slot 1 = ALU 0x55, `rdata` 0xDEADBEEF → `res_0` 0xDEADBEEF, `res_1` 0x55, stall 3 cycles.
- Slot 0 = SB 0x1A at 0x103, slot 1 = LH at 0x202, `rdata` 0x80010000 → be 4'b1000, wdata 0x1A1A1A1A; then `res_1` 0xFFFF8001; order slot 0 before slot 1.
- Two stores, `gnt` withheld 4 cycles on the first → req held steady, stall stays high, exactly 2 grants.
- DONE with `adv_i`=0 for 5 cycles → no new request, results stable; `adv_i`=1 → IDLE.
- LW at 0x102 → no request, `misalign_o`=2'b01, `res_0`=0; slot 1 load still executes.
- `reset_i` during WAIT0, then a late `rvalid` → IDLE, req 0, `ld_0` stays 0.

Source files
------------

// File: rtl/lsu_dual_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_dual_port_pkg
//  Description : Control-word field positions, access sizes and FSM state
//                encoding shared by the dual-slot load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_dual_port_pkg;

    // Per-slot control word; an all-zero word is a pipeline bubble.
    localparam int CTRL_BUS     = 8;
    localparam int MEM_READ     = 0;
    localparam int MEM_WRITE    = 1;
    localparam int MEM_SIZE_LO  = 2;
    localparam int MEM_SIZE_HI  = 3;
    localparam int MEM_UNSIGNED = 4;
    localparam int REG_WRITE    = 5;

    typedef logic [CTRL_BUS-1:0] ctrl_bus_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_DONE  = 3'd5
    } lsu_state_e;

    function automatic logic is_mem_op(input ctrl_bus_t ctrl);
        return ctrl[MEM_READ] | ctrl[MEM_WRITE];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_dual_port_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Per-slot byte-enable generation, store-lane replication,
//                load-data extraction/extension and misalignment detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_dual_port_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        zext,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic        misaligned
);

    logic [31:0] w_shift;

    // Size-dependent lane selection; a size code of 3 behaves as a word.
    always_comb begin
        w_shift    = rdata >> {addr_lo, 3'b000};
        be         = 4'hF;
        wdata      = st_data;
        ld_data    = w_shift;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: begin
                be      = 4'b0001 << addr_lo;
                wdata   = {4{st_data[7:0]}};
                ld_data = {{24{~zext & w_shift[7]}}, w_shift[7:0]};
            end
            SIZE_HALF: begin
                be         = 4'b0011 << addr_lo;
                wdata      = {2{st_data[15:0]}};
                ld_data    = {{16{~zext & w_shift[15]}}, w_shift[15:0]};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_dual_port.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_dual_port
//  Description : Serialises the memory operations of a two-slot bundle onto
//                one data-memory request/grant port (slot 0 first), stalls
//                the backend while accesses are outstanding and returns a
//                per-slot result (load data or ALU value).
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_dual_port
    import lsu_dual_port_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                adv_i,
    input  logic [31:0]         alu_0_i,
    input  logic [31:0]         alu_1_i,
    input  logic [CTRL_BUS-1:0] ctrl0_i,
    input  logic [CTRL_BUS-1:0] ctrl1_i,
    input  logic [31:0]         st_data_0_i,
    input  logic [31:0]         st_data_1_i,
    output logic                dmem_req_o,
    output logic                dmem_we_o,
    output logic [ADDR_W-1:0]   dmem_addr_o,
    output logic [3:0]          dmem_be_o,
    output logic [31:0]         dmem_wdata_o,
    input  logic                dmem_gnt_i,
    input  logic                dmem_rvalid_i,
    input  logic [31:0]         dmem_rdata_i,
    output logic                mem_stall_o,
    output logic [31:0]         res_0_o,
    output logic [31:0]         res_1_o,
    output logic [1:0]          misalign_o
);

    lsu_state_e  r_state;
    lsu_state_e  w_state_nxt;
    logic [31:0] r_ld [2];

    ctrl_bus_t   w_ctrl    [2];
    logic [31:0] w_alu     [2];
    logic [31:0] w_st      [2];
    logic [3:0]  w_be      [2];
    logic [31:0] w_wdata   [2];
    logic [31:0] w_ld_data [2];
    logic [31:0] w_res     [2];
    logic [1:0]  w_mem;
    logic [1:0]  w_store;
    logic [1:0]  w_load;
    logic [1:0]  w_mis;
    logic [1:0]  w_need;
    logic [1:0]  w_align_mis;

    logic              w_req_nxt;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [3:0]        w_be_nxt;
    logic [31:0]       w_wdata_nxt;
    lsu_state_e        w_after0;

    // Upper control bits belong to other pipeline stages.
    logic w_unused_ctrl;
    assign w_unused_ctrl = ^{ctrl0_i[CTRL_BUS-1:MEM_UNSIGNED+1],
                             ctrl1_i[CTRL_BUS-1:MEM_UNSIGNED+1]};

    assign w_ctrl[0] = ctrl0_i;
    assign w_ctrl[1] = ctrl1_i;
    assign w_alu[0]  = alu_0_i;
    assign w_alu[1]  = alu_1_i;
    assign w_st[0]   = st_data_0_i;
    assign w_st[1]   = st_data_1_i;

    for (genvar s = 0; s < 2; s++) begin : g_slot
        lsu_align u_align (
            .addr_lo    (w_alu[s][1:0]),
            .size       (w_ctrl[s][MEM_SIZE_HI:MEM_SIZE_LO]),
            .zext       (w_ctrl[s][MEM_UNSIGNED]),
            .st_data    (w_st[s]),
            .rdata      (dmem_rdata_i),
            .be         (w_be[s]),
            .wdata      (w_wdata[s]),
            .ld_data    (w_ld_data[s]),
            .misaligned (w_align_mis[s])
        );
        // A slot with the write bit set is a store; read-only is a load.
        assign w_mem[s]   = is_mem_op(w_ctrl[s]);
        assign w_store[s] = w_ctrl[s][MEM_WRITE];
        assign w_load[s]  = w_ctrl[s][MEM_READ] & ~w_ctrl[s][MEM_WRITE];
        assign w_mis[s]   = w_mem[s] & w_align_mis[s];
        assign w_need[s]  = w_mem[s] & ~w_align_mis[s];
        assign w_res[s]   = w_mis[s] ? 32'h0 : (w_load[s] ? r_ld[s] : w_alu[s]);
    end

    assign res_0_o = w_res[0];
    assign res_1_o = w_res[1];

    assign mem_stall_o = (r_state == S_REQ0) || (r_state == S_WAIT0) ||
                         (r_state == S_REQ1) || (r_state == S_WAIT1) ||
                         ((r_state == S_IDLE) && (|w_mem));

    // Where to go once slot 0 is finished (or skipped as misaligned).
    assign w_after0 = w_need[1] ? S_REQ1 : S_DONE;

    // Next-state logic; misaligned slots are skipped without a request.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_need[0])      w_state_nxt = S_REQ0;
                else if (w_need[1]) w_state_nxt = S_REQ1;
                else if (|w_mem)    w_state_nxt = S_DONE;
            end
            S_REQ0:  if (dmem_gnt_i)    w_state_nxt = w_store[0] ? w_after0 : S_WAIT0;
            S_WAIT0: if (dmem_rvalid_i) w_state_nxt = w_after0;
            S_REQ1:  if (dmem_gnt_i)    w_state_nxt = w_store[1] ? S_DONE : S_WAIT1;
            S_WAIT1: if (dmem_rvalid_i) w_state_nxt = S_DONE;
            S_DONE:  if (adv_i)         w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    // Request fields for the coming cycle, taken from the slot being entered.
    always_comb begin
        w_req_nxt   = 1'b0;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = '0;
        w_be_nxt    = 4'h0;
        w_wdata_nxt = 32'h0;
        if (w_state_nxt == S_REQ0) begin
            w_req_nxt   = 1'b1;
            w_we_nxt    = w_store[0];
            w_addr_nxt  = {w_alu[0][ADDR_W-1:2], 2'b00};
            w_be_nxt    = w_be[0];
            w_wdata_nxt = w_wdata[0];
        end else if (w_state_nxt == S_REQ1) begin
            w_req_nxt   = 1'b1;
            w_we_nxt    = w_store[1];
            w_addr_nxt  = {w_alu[1][ADDR_W-1:2], 2'b00};
            w_be_nxt    = w_be[1];
            w_wdata_nxt = w_wdata[1];
        end
    end

    // State, registered memory port, load capture and misalignment flags.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state      <= S_IDLE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= 4'h0;
            dmem_wdata_o <= 32'h0;
            r_ld[0]      <= 32'h0;
            r_ld[1]      <= 32'h0;
            misalign_o   <= 2'b00;
        end else begin
            r_state      <= w_state_nxt;
            dmem_req_o   <= w_req_nxt;
            dmem_we_o    <= w_we_nxt;
            dmem_addr_o  <= w_addr_nxt;
            dmem_be_o    <= w_be_nxt;
            dmem_wdata_o <= w_wdata_nxt;
            if ((r_state == S_WAIT0) && dmem_rvalid_i) r_ld[0] <= w_ld_data[0];
            if ((r_state == S_WAIT1) && dmem_rvalid_i) r_ld[1] <= w_ld_data[1];
            // Bundle is stable from IDLE until DONE, so sampling here holds.
            if (r_state == S_IDLE) misalign_o <= w_mis;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_dual_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_dual_port
//  Description : Self-checking bench for lsu_dual_port with a memory
//                responder and request/result scoreboards.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_dual_port;
    import lsu_dual_port_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] rdata;
    } req_t;

    typedef struct {
        logic [31:0] r0;
        logic [31:0] r1;
        logic [1:0]  mis;
        int          stall;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        adv;
    logic [31:0] alu0, alu1, sd0, sd1;
    ctrl_bus_t   ctrl0, ctrl1;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        stall;
    logic [31:0] res0, res1;
    logic [1:0]  mis;

    req_t req_q[$];
    res_t res_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   grants   = 0;

    always #5 clk = ~clk;

    lsu_dual_port #(.ADDR_W(32)) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .adv_i         (adv),
        .alu_0_i       (alu0),
        .alu_1_i       (alu1),
        .ctrl0_i       (ctrl0),
        .ctrl1_i       (ctrl1),
        .st_data_0_i   (sd0),
        .st_data_1_i   (sd1),
        .dmem_req_o    (dmem_req),
        .dmem_we_o     (dmem_we),
        .dmem_addr_o   (dmem_addr),
        .dmem_be_o     (dmem_be),
        .dmem_wdata_o  (dmem_wdata),
        .dmem_gnt_i    (gnt),
        .dmem_rvalid_i (rvalid),
        .dmem_rdata_i  (rdata),
        .mem_stall_o   (stall),
        .res_0_o       (res0),
        .res_1_o       (res1),
        .misalign_o    (mis)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic ctrl_bus_t mk(input logic rd, input logic wr,
                                     input logic [1:0] sz, input logic uns);
        ctrl_bus_t c;
        c = '0;
        c[MEM_READ]                = rd;
        c[MEM_WRITE]               = wr;
        c[MEM_SIZE_HI:MEM_SIZE_LO] = sz;
        c[MEM_UNSIGNED]            = uns;
        c[REG_WRITE]               = ~wr;
        return c;
    endfunction

    task automatic push_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input int gd, input int rd,
                            input logic [31:0] rdat);
        req_t e;
        e.we = we; e.addr = addr; e.be = be; e.wdata = wdata;
        e.gnt_dly = gd; e.rv_dly = rd; e.rdata = rdat;
        req_q.push_back(e);
    endtask

    // Grant/rvalid must never coincide on the memory port.
    always @(posedge clk) begin
        if (!rst) assert (!(gnt && rvalid)) else $error("protocol: rvalid together with gnt");
    end

    // Memory responder: grants after the queued delay, checks every request.
    initial begin : responder
        int          wait_cnt;
        int          rv_cnt;
        logic        rv_pend;
        logic [31:0] rv_data;
        req_t        e;
        wait_cnt = 0; rv_cnt = 0; rv_pend = 1'b0; rv_data = '0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        forever begin
            @(negedge clk);
            gnt = 1'b0;
            rvalid = 1'b0;
            if (rv_pend) begin
                if (rv_cnt == 0) begin
                    rvalid  = 1'b1;
                    rdata   = rv_data;
                    rv_pend = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end else if (dmem_req && !rst) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_req", req_q.size(), 1);
                end else if (wait_cnt < req_q[0].gnt_dly) begin
                    chk("req_steady", {dmem_we, dmem_addr, dmem_be, dmem_wdata},
                        {req_q[0].we, req_q[0].addr, req_q[0].be, req_q[0].wdata});
                    wait_cnt++;
                end else begin
                    e = req_q.pop_front();
                    gnt = 1'b1;
                    grants++;
                    wait_cnt = 0;
                    chk("req_we",    dmem_we,    e.we);
                    chk("req_addr",  dmem_addr,  e.addr);
                    chk("req_be",    dmem_be,    e.be);
                    chk("req_wdata", dmem_wdata, e.wdata);
                    if (!dmem_we) begin
                        rv_pend = 1'b1;
                        rv_cnt  = e.rv_dly;
                        rv_data = e.rdata;
                    end
                end
            end
        end
    end

    // Apply a bundle (state must be IDLE), count stall cycles, check results.
    task automatic run_bundle(input string name,
                              input ctrl_bus_t c0, input logic [31:0] a0, input logic [31:0] s0,
                              input ctrl_bus_t c1, input logic [31:0] a1, input logic [31:0] s1,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [1:0] emis, input int estall);
        res_t r;
        res_t got;
        int   cnt;
        r.r0 = e0; r.r1 = e1; r.mis = emis; r.stall = estall;
        res_q.push_back(r);
        ctrl0 = c0; alu0 = a0; sd0 = s0;
        ctrl1 = c1; alu1 = a1; sd1 = s1;
        adv = 1'b0;
        #1;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (!stall) break;
            cnt++;
            @(negedge clk);
            #1;
        end
        got = res_q.pop_front();
        chk({name, "_stall_low"}, stall, 1'b0);
        chk({name, "_stall_cycles"}, cnt, got.stall);
        chk({name, "_res0"}, res0, got.r0);
        chk({name, "_res1"}, res1, got.r1);
        chk({name, "_misalign"}, mis, got.mis);
        chk({name, "_req_q_empty"}, req_q.size(), 0);
    endtask

    task automatic advance();
        adv = 1'b1;
        @(negedge clk);
        #1;
        adv = 1'b0;
    endtask

    initial begin : main
        int g0;
        rst = 1'b1; adv = 1'b0;
        ctrl0 = '0; ctrl1 = '0; alu0 = '0; alu1 = '0; sd0 = '0; sd1 = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req",   dmem_req,   1'b0);
        chk("rst_we",    dmem_we,    1'b0);
        chk("rst_addr",  dmem_addr,  32'h0);
        chk("rst_be",    dmem_be,    4'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_mis",   mis,        2'b00);
        chk("rst_stall", stall,      1'b0);
        rst = 1'b0;
        @(negedge clk);
        #1;

        // LW at 0x100, ALU in slot 1.
        push_req(1'b0, 32'h100, 4'hF, 32'h0, 0, 0, 32'hDEADBEEF);
        run_bundle("lw", mk(1, 0, SIZE_WORD, 0), 32'h100, 32'h0,
                   mk(0, 0, 2'd0, 0), 32'h55, 32'h0,
                   32'hDEADBEEF, 32'h55, 2'b00, 3);
        advance();

        // SB 0x1A at 0x103 then LH at 0x202.
        push_req(1'b1, 32'h100, 4'b1000, 32'h1A1A1A1A, 0, 0, 32'h0);
        push_req(1'b0, 32'h200, 4'b1100, 32'h99889988, 0, 0, 32'h80010000);
        run_bundle("sb_lh", mk(0, 1, SIZE_BYTE, 0), 32'h103, 32'h1A,
                   mk(1, 0, SIZE_HALF, 0), 32'h202, 32'h77669988,
                   32'h103, 32'hFFFF8001, 2'b00, 4);
        advance();

        // Two stores, first grant withheld four cycles.
        g0 = grants;
        push_req(1'b1, 32'h300, 4'hF, 32'hAABBCCDD, 4, 0, 32'h0);
        push_req(1'b1, 32'h304, 4'b1100, 32'h12341234, 0, 0, 32'h0);
        run_bundle("sw_sh", mk(0, 1, SIZE_WORD, 0), 32'h300, 32'hAABBCCDD,
                   mk(0, 1, SIZE_HALF, 0), 32'h306, 32'h00001234,
                   32'h300, 32'h306, 2'b00, 7);
        chk("sw_sh_grants", grants - g0, 2);
        advance();

        // LBU at 0x401, then hold DONE with adv low.
        push_req(1'b0, 32'h400, 4'b0010, 32'h0, 0, 0, 32'h0000AB00);
        run_bundle("lbu", mk(1, 0, SIZE_BYTE, 1), 32'h401, 32'h0,
                   mk(0, 0, 2'd0, 0), 32'h77, 32'h0,
                   32'h000000AB, 32'h77, 2'b00, 3);
        g0 = grants;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("hold_req", dmem_req, 1'b0);
            chk("hold_res0", res0, 32'h000000AB);
        end
        chk("hold_grants", grants - g0, 0);
        adv = 1'b1;
        @(negedge clk);
        #1;
        chk("adv_idle_stall", stall, 1'b1);
        ctrl0 = '0; ctrl1 = '0; adv = 1'b0;
        @(negedge clk);
        #1;
        chk("adv_idle_req", dmem_req, 1'b0);
        chk("adv_idle_stall_low", stall, 1'b0);

        // Misaligned LW in slot 0, aligned LW in slot 1 still runs.
        push_req(1'b0, 32'h504, 4'hF, 32'h0, 0, 0, 32'hCAFEF00D);
        run_bundle("mis_lw", mk(1, 0, SIZE_WORD, 0), 32'h102, 32'h0,
                   mk(1, 0, SIZE_WORD, 0), 32'h504, 32'h0,
                   32'h0, 32'hCAFEF00D, 2'b01, 3);
        advance();

        // Misaligned SW alone: no request, straight to DONE.
        g0 = grants;
        run_bundle("mis_sw", mk(0, 1, SIZE_WORD, 0), 32'h801, 32'h11111111,
                   '0, 32'h0, 32'h0,
                   32'h0, 32'h0, 2'b01, 1);
        chk("mis_sw_grants", grants - g0, 0);
        advance();

        // Signed byte at lane 3 and unsigned half at lane 0.
        push_req(1'b0, 32'h600, 4'b1000, 32'h0, 0, 0, 32'h80000000);
        push_req(1'b0, 32'h600, 4'b0011, 32'h0, 0, 0, 32'h0000FFFE);
        run_bundle("lb_lhu", mk(1, 0, SIZE_BYTE, 0), 32'h603, 32'h0,
                   mk(1, 0, SIZE_HALF, 1), 32'h600, 32'h0,
                   32'hFFFFFF80, 32'h0000FFFE, 2'b00, 5);
        advance();

        // No memory op: zero stall, results are ALU values.
        run_bundle("alu", mk(0, 0, 2'd0, 0), 32'h1234, 32'h0,
                   mk(0, 0, 2'd0, 0), 32'h5678, 32'h0,
                   32'h1234, 32'h5678, 2'b00, 0);
        chk("alu_req", dmem_req, 1'b0);
        advance();

        // Reset during WAIT0, then a late rvalid that must be ignored.
        push_req(1'b0, 32'h700, 4'hF, 32'h0, 0, 1, 32'hFFFFFFFF);
        push_req(1'b0, 32'h700, 4'hF, 32'h0, 0, 0, 32'h13572468);
        ctrl0 = mk(1, 0, SIZE_WORD, 0); alu0 = 32'h700; sd0 = '0;
        ctrl1 = '0; alu1 = '0; sd1 = '0;
        @(negedge clk);
        #1;
        chk("rst_mid_req_issued", dmem_req, 1'b1);
        @(negedge clk);
        #1;
        chk("rst_mid_wait_stall", stall, 1'b1);
        chk("rst_mid_wait_req", dmem_req, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_req_dropped", dmem_req, 1'b0);
        chk("rst_mid_res0", res0, 32'h0);
        @(negedge clk);
        #1;
        chk("rst_mid_reissue_req", dmem_req, 1'b1);
        chk("rst_mid_ld0_kept", res0, 32'h0);
        for (int i = 0; i < 60; i++) begin
            if (!stall) break;
            @(negedge clk);
            #1;
        end
        chk("rst_mid_done_stall", stall, 1'b0);
        chk("rst_mid_final_res0", res0, 32'h13572468);
        chk("rst_mid_req_q_empty", req_q.size(), 0);
        advance();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
